// File: rtl/neuron_mac_fp32_if.sv
// Beat/result bus of the neuron MAC: operand beats in, one accumulated result pulse out.
interface neuron_mac_fp32_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  i_valid;
    logic                  i_ready;
    logic [DATA_WIDTH-1:0] i_data;
    logic [DATA_WIDTH-1:0] i_weight;
    logic [DATA_WIDTH-1:0] i_bias;
    logic [DATA_WIDTH-1:0] o_data;
    logic                  o_valid;

    modport master (output i_valid, i_data, i_weight, i_bias, input i_ready, o_data, o_valid);
    modport slave  (input i_valid, i_data, i_weight, i_bias, output i_ready, o_data, o_valid);
endinterface

// File: rtl/neuron_mac_fp32.sv
// fp32 neuron pre-activation: bias + sum(x[k]*w[k]) via a pipelined multiplier, a product FIFO
// and a serial accumulator around a pipelined adder. Denormals flush to zero.
module multiplier_floating_point32 #(
    parameter int unsigned Latency = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        valid_out,
    output logic [31:0] result
);
    logic [Latency-1:0] vld_q;
    logic [31:0]        res_q [Latency];
    logic [31:0]        prod;
    logic [47:0]        p;
    logic signed [10:0] e;
    logic [22:0]        mant;
    logic [23:0]        rnd;
    logic               sign, g, st;

    always_comb begin
        sign = a[31] ^ b[31];
        p    = {1'b1, a[22:0]} * {1'b1, b[22:0]};
        e    = $signed({3'b0, a[30:23]}) + $signed({3'b0, b[30:23]}) - 11'sd127;
        if (p[47]) begin
            mant = p[46:24];
            g    = p[23];
            st   = |p[22:0];
            e    = e + 11'sd1;
        end else begin
            mant = p[45:23];
            g    = p[22];
            st   = |p[21:0];
        end
        rnd = {1'b0, mant} + 24'(g & (st | mant[0]));
        if (rnd[23]) e = e + 11'sd1;
        prod = {sign, 31'b0};
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) prod = {sign, 31'b0};
        else if (e >= 11'sd255)                   prod = {sign, 8'hff, 23'b0};
        else if (e <= 11'sd0)                     prod = {sign, 31'b0};
        else                                      prod = {sign, e[7:0], rnd[22:0]};
    end

    // Only the valid chain is reset, so ops issued before a reset never emerge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) vld_q <= '0;
        else     vld_q <= {vld_q[Latency-2:0], valid_in};
    end

    always_ff @(posedge clk) begin
        res_q[0] <= prod;
        for (int unsigned i = 1; i < Latency; i++) res_q[i] <= res_q[i-1];
    end

    assign valid_out = vld_q[Latency-1];
    assign result    = res_q[Latency-1];
endmodule

module adder_floating_point32 #(
    parameter int unsigned Latency = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        valid_out,
    output logic [31:0] result
);
    logic [Latency-1:0] vld_q;
    logic [31:0]        res_q [Latency];
    logic [31:0]        sum, big, sml;
    logic [7:0]         d;
    logic [4:0]         dd, lz;
    logic [55:0]        wide;
    logic [26:0]        mb, ms;
    logic [27:0]        s28;
    logic [26:0]        n;
    logic signed [10:0] e;
    logic [23:0]        rnd;
    logic               found, g, st;

    always_comb begin
        big  = (a[30:0] < b[30:0]) ? b : a;
        sml  = (a[30:0] < b[30:0]) ? a : b;
        d    = big[30:23] - sml[30:23];
        dd   = (d > 8'd28) ? 5'd28 : d[4:0];
        // Small operand carries guard/round/sticky bits; anything shifted past them is sticky.
        wide = {1'b1, sml[22:0], 3'b0, 29'b0} >> dd;
        ms   = {wide[55:30], wide[29] | (|wide[28:0])};
        mb   = {1'b1, big[22:0], 3'b0};
        s28  = (a[31] ^ b[31]) ? ({1'b0, mb} - {1'b0, ms}) : ({1'b0, mb} + {1'b0, ms});
        e    = $signed({3'b0, big[30:23]});
        lz    = 5'd0;
        found = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (!found && s28[i]) begin
                lz    = 5'(26 - i);
                found = 1'b1;
            end
        end
        if (s28[27]) begin
            n = {s28[27:2], s28[1] | s28[0]};
            e = e + 11'sd1;
        end else begin
            n = s28[26:0] << lz;
            e = e - $signed({6'b0, lz});
        end
        g   = n[2];
        st  = n[1] | n[0];
        rnd = {1'b0, n[25:3]} + 24'(g & (st | n[3]));
        if (rnd[23]) e = e + 11'sd1;
        sum = {big[31], e[7:0], rnd[22:0]};
        if (a[30:23] == 8'd0 && b[30:23] == 8'd0) sum = {a[31] & b[31], 31'b0};
        else if (a[30:23] == 8'd0)                sum = b;
        else if (b[30:23] == 8'd0)                sum = a;
        else if (s28 == 28'd0)                    sum = 32'd0;
        else if (e >= 11'sd255)                   sum = {big[31], 8'hff, 23'b0};
        else if (e <= 11'sd0)                     sum = {big[31], 31'b0};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) vld_q <= '0;
        else     vld_q <= {vld_q[Latency-2:0], valid_in};
    end

    always_ff @(posedge clk) begin
        res_q[0] <= sum;
        for (int unsigned i = 1; i < Latency; i++) res_q[i] <= res_q[i-1];
    end

    assign valid_out = vld_q[Latency-1];
    assign result    = res_q[Latency-1];
endmodule

module neuron_mac_fp32 #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned NUM_INPUTS  = 8,
    parameter int unsigned MUL_LATENCY = 7,
    parameter int unsigned ADD_LATENCY = 7,
    parameter int unsigned FIFO_DEPTH  = 8
) (
    input logic              clk,
    input logic              rst_n,
    neuron_mac_fp32_if.slave bus
);
    localparam int unsigned CW = $clog2(NUM_INPUTS + 1);
    localparam int unsigned FW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

    state_e                state_q, state_d;
    logic [CW-1:0]         in_cnt_q, in_cnt_d, acc_cnt_q, acc_cnt_d;
    logic [FW-1:0]         infl_q, infl_d, fcnt_q, fcnt_d;
    logic [AW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [DATA_WIDTH-1:0] fifo_q [FIFO_DEPTH];
    logic                  rdy_q, rdy_d;
    logic                  xfer, push, pop;
    logic                  mul_vout, add_vin, add_vout;
    logic [DATA_WIDTH-1:0] mul_res, add_res;

    assign xfer    = bus.i_valid & rdy_q;
    assign push    = mul_vout;
    assign pop     = (state_q == StIssue);
    assign add_vin = pop;

    multiplier_floating_point32 #(.Latency(MUL_LATENCY)) u_mul (
        .clk      (clk),
        .rst      (rst_n),
        .valid_in (xfer),
        .a        (bus.i_data),
        .b        (bus.i_weight),
        .valid_out(mul_vout),
        .result   (mul_res)
    );

    adder_floating_point32 #(.Latency(ADD_LATENCY)) u_add (
        .clk      (clk),
        .rst      (rst_n),
        .valid_in (add_vin),
        .a        (acc_q),
        .b        (fifo_q[rptr_q]),
        .valid_out(add_vout),
        .result   (add_res)
    );

    always_comb begin
        state_d   = state_q;
        in_cnt_d  = in_cnt_q;
        acc_cnt_d = acc_cnt_q;
        acc_d     = acc_q;
        wptr_d    = push ? wptr_q + AW'(1) : wptr_q;
        rptr_d    = pop ? rptr_q + AW'(1) : rptr_q;
        infl_d    = infl_q;
        fcnt_d    = fcnt_q;
        unique case ({xfer, push})
            2'b10:   infl_d = infl_q + FW'(1);
            2'b01:   infl_d = infl_q - FW'(1);
            default: infl_d = infl_q;
        endcase
        unique case ({push, pop})
            2'b10:   fcnt_d = fcnt_q + FW'(1);
            2'b01:   fcnt_d = fcnt_q - FW'(1);
            default: fcnt_d = fcnt_q;
        endcase
        if (xfer) begin
            in_cnt_d = in_cnt_q + CW'(1);
            if (in_cnt_q == '0) acc_d = bus.i_bias;
        end
        unique case (state_q)
            StIdle:  if (fcnt_q != '0) state_d = StIssue;
            StIssue: state_d = StWait;
            StWait: begin
                if (add_vout) begin
                    acc_d     = add_res;
                    acc_cnt_d = acc_cnt_q + CW'(1);
                    if (32'(acc_cnt_d) == NUM_INPUTS) state_d = StDone;
                    else if (fcnt_q != '0)            state_d = StIssue;
                    else                              state_d = StIdle;
                end
            end
            StDone: begin
                in_cnt_d  = '0;
                acc_cnt_d = '0;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
        // Products already in the multiplier count against FIFO space, so a push never overflows.
        rdy_d = (32'(in_cnt_d) < NUM_INPUTS) && ((32'(fcnt_d) + 32'(infl_d)) < FIFO_DEPTH);
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q   <= StIdle;
            in_cnt_q  <= '0;
            acc_cnt_q <= '0;
            infl_q    <= '0;
            fcnt_q    <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            acc_q     <= '0;
            rdy_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_cnt_q  <= in_cnt_d;
            acc_cnt_q <= acc_cnt_d;
            infl_q    <= infl_d;
            fcnt_q    <= fcnt_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            acc_q     <= acc_d;
            rdy_q     <= rdy_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_q[wptr_q] <= mul_res;
    end

    assert property (@(posedge clk) disable iff (rst_n)
        !(push && !pop && (32'(fcnt_q) == FIFO_DEPTH)));

    assign bus.i_ready = rdy_q;
    assign bus.o_valid = (state_q == StDone);
    assign bus.o_data  = (state_q == StDone) ? acc_q : '0;
endmodule
